// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between the ALU and load paths and
// tracks in-flight destinations so that decode can stall on busy source registers.
module reg_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_vld,
    input  logic [3:0]        alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_rdy,
    input  logic              mem_vld,
    input  logic [3:0]        mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_rdy,
    input  logic              claim_vld,
    input  logic [3:0]        claim_reg,
    input  logic              rs1_en,
    input  logic              rs2_en,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    output logic              stall,
    output logic [15:0]       busy,
    output logic              claim_err,
    output logic              RegWrite,
    output logic [3:0]        Write_Reg,
    output logic [DATA_W-1:0] Write_Bus
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    logic [15:0]       busy_q, busy_d, set_m, clr_m;
    logic              regwrite_q, claim_err_q;
    logic [3:0]        wreg_q;
    logic [DATA_W-1:0] wbus_q;
    logic              alu_win;

    // MEM has priority unless the ALU has lost STARVE_MAX times in a row
    assign alu_win = alu_vld & (~mem_vld | (starve_q == SMAX));
    assign alu_rdy = ~rst & alu_win;
    assign mem_rdy = ~rst & mem_vld & ~alu_win;

    always_comb begin
        starve_d = (!alu_vld || alu_rdy) ? 4'd0 : (starve_q == SMAX ? starve_q : starve_q + 4'd1);
        set_m    = claim_vld ? 16'(1) << claim_reg : 16'd0;
        clr_m    = regwrite_q ? 16'(1) << wreg_q : 16'd0;
        busy_d   = (busy_q & ~clr_m) | set_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            busy_q      <= '0;
            regwrite_q  <= 1'b0;
            claim_err_q <= 1'b0;
            wreg_q      <= '0;
            wbus_q      <= '0;
        end else begin
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            regwrite_q  <= alu_rdy | mem_rdy;
            claim_err_q <= claim_vld & busy_q[claim_reg];
            if (alu_rdy | mem_rdy) begin
                wreg_q <= alu_rdy ? alu_reg : mem_reg;
                wbus_q <= alu_rdy ? alu_data : mem_data;
            end
        end
    end

    // No bypass: a register committing this cycle still stalls
    assign stall     = (rs1_en & busy_q[rs1]) | (rs2_en & busy_q[rs2]);
    assign busy      = busy_q;
    assign claim_err = claim_err_q;
    assign RegWrite  = regwrite_q;
    assign Write_Reg = wreg_q;
    assign Write_Bus = wbus_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed test of arbitration, write-port timing, scoreboard and async reset.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        alu_vld = 0, mem_vld = 0, claim_vld = 0, rs1_en = 0, rs2_en = 0;
    logic [3:0]  alu_reg = 0, mem_reg = 0, claim_reg = 0, rs1 = 0, rs2 = 0;
    logic [15:0] alu_data = 0, mem_data = 0;
    logic        alu_rdy, mem_rdy, stall, claim_err, RegWrite;
    logic [15:0] busy, Write_Bus;
    logic [3:0]  Write_Reg;
    int checks = 0, errors = 0;

    reg_wb_arbiter #(.DATA_W(16), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_reg(alu_reg), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .mem_vld(mem_vld), .mem_reg(mem_reg), .mem_data(mem_data), .mem_rdy(mem_rdy),
        .claim_vld(claim_vld), .claim_reg(claim_reg),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1(rs1), .rs2(rs2),
        .stall(stall), .busy(busy), .claim_err(claim_err),
        .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state, requests masked during reset
        @(negedge clk);
        alu_vld = 1; mem_vld = 1;
        #1;
        chk("rst_alu_rdy", alu_rdy, 0);
        chk("rst_mem_rdy", mem_rdy, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wreg", Write_Reg, 0);
        chk("rst_wbus", Write_Bus, 0);
        chk("rst_claim_err", claim_err, 0);
        @(negedge clk);
        alu_vld = 0; mem_vld = 0; rst = 0;

        // single ALU write to r3
        @(negedge clk);
        claim_vld = 1; claim_reg = 3;
        @(negedge clk);
        claim_vld = 0; alu_vld = 1; alu_reg = 3; alu_data = 16'hBEEF; rs1 = 3; rs1_en = 1;
        #1;
        chk("a_alu_rdy", alu_rdy, 1);
        chk("a_mem_rdy", mem_rdy, 0);
        chk("a_busy", busy, 16'h0008);
        chk("a_stall", stall, 1);
        @(negedge clk);
        alu_vld = 0;
        #1;
        chk("a_regwrite", RegWrite, 1);
        chk("a_wreg", Write_Reg, 3);
        chk("a_wbus", Write_Bus, 16'hBEEF);
        chk("a_busy_commit", busy, 16'h0008);
        chk("a_stall_commit", stall, 1);
        @(negedge clk);
        #1;
        chk("a_regwrite_off", RegWrite, 0);
        chk("a_busy_clear", busy, 0);
        chk("a_stall_clear", stall, 0);
        chk("a_wreg_hold", Write_Reg, 3);
        chk("a_wbus_hold", Write_Bus, 16'hBEEF);
        rs1_en = 0;

        // sustained contention: MEM,MEM,MEM,ALU repeating
        @(negedge clk);
        alu_vld = 1; alu_reg = 1; alu_data = 16'h1111;
        mem_vld = 1; mem_reg = 2; mem_data = 16'h2222;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("c_alu_rdy", alu_rdy, (k % 4 == 3));
            chk("c_mem_rdy", mem_rdy, (k % 4 != 3));
            if (k > 0) begin
                chk("c_regwrite", RegWrite, 1);
                chk("c_wreg", Write_Reg, ((k - 1) % 4 == 3) ? 1 : 2);
            end
            @(negedge clk);
        end
        alu_vld = 0; mem_vld = 0;
        #1;
        chk("c_last_wreg", Write_Reg, 1);
        chk("c_last_wbus", Write_Bus, 16'h1111);

        // same-register collision on r5
        @(negedge clk);
        alu_vld = 1; alu_reg = 5; alu_data = 16'h0001;
        mem_vld = 1; mem_reg = 5; mem_data = 16'h0002;
        #1;
        chk("s_mem_rdy", mem_rdy, 1);
        chk("s_alu_rdy", alu_rdy, 0);
        @(negedge clk);
        mem_vld = 0;
        #1;
        chk("s_alu_rdy2", alu_rdy, 1);
        chk("s_wreg1", Write_Reg, 5);
        chk("s_wbus1", Write_Bus, 16'h0002);
        @(negedge clk);
        alu_vld = 0;
        #1;
        chk("s_regwrite2", RegWrite, 1);
        chk("s_wreg2", Write_Reg, 5);
        chk("s_wbus2", Write_Bus, 16'h0001);

        // scoreboard corner cases on r7
        @(negedge clk);
        claim_vld = 1; claim_reg = 7;
        @(negedge clk);
        claim_vld = 0; alu_vld = 1; alu_reg = 7; alu_data = 16'h0777;
        #1;
        chk("b_busy7", busy, 16'h0080);
        chk("b_claim_err0", claim_err, 0);
        @(negedge clk);
        alu_vld = 0; claim_vld = 1; claim_reg = 7;
        #1;
        chk("b_commit7", RegWrite, 1);
        chk("b_commit7_reg", Write_Reg, 7);
        @(negedge clk);
        claim_vld = 0; rs2 = 7; rs2_en = 0;
        #1;
        chk("b_set_wins", busy, 16'h0080);
        chk("b_rs2_dis_stall", stall, 0);
        rs2_en = 1;
        #1;
        chk("b_rs2_en_stall", stall, 1);
        rs2_en = 0;
        @(negedge clk);
        claim_vld = 1; claim_reg = 7;
        #1;
        chk("b_err_before", claim_err, 0);
        @(negedge clk);
        claim_vld = 0;
        #1;
        chk("b_err_pulse", claim_err, 1);
        chk("b_busy_kept", busy, 16'h0080);
        @(negedge clk);
        #1;
        chk("b_err_end", claim_err, 0);

        // build RegWrite=1 with busy=0014, then async reset mid-cycle
        @(negedge clk);
        claim_vld = 1; claim_reg = 2; alu_vld = 1; alu_reg = 7; alu_data = 16'hAAAA;
        @(negedge clk);
        claim_reg = 4; alu_vld = 0;
        @(negedge clk);
        claim_vld = 0; mem_vld = 1; mem_reg = 9; mem_data = 16'h9999;
        @(negedge clk);
        mem_vld = 0;
        #1;
        chk("r_pre_busy", busy, 16'h0014);
        chk("r_pre_regwrite", RegWrite, 1);
        #1 rst = 1;
        #1;
        chk("r_regwrite", RegWrite, 0);
        chk("r_busy", busy, 0);
        chk("r_wreg", Write_Reg, 0);
        chk("r_wbus", Write_Bus, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mem_vld = 1; mem_reg = 6; mem_data = 16'h1234;
        #1;
        chk("r_post_mem_rdy", mem_rdy, 1);
        @(negedge clk);
        mem_vld = 0;
        #1;
        chk("r_post_regwrite", RegWrite, 1);
        chk("r_post_wreg", Write_Reg, 6);
        chk("r_post_wbus", Write_Bus, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and scoreboard for the 16-entry, 16-bit register file. It shares the file's single write port between the ALU result path and the memory-load path. It tracks which destination registers have writes in flight and raises a decode stall when a source register is still pending. It sits between the execute/memory stages and the register file write port (RegWrite / Write_Reg / Write_Bus).

## Interface
Parameters:
- DATA_W, 16, write data width.
- STARVE_MAX, 3, consecutive lost arbitrations after which the ALU requester is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_vld  in  1  ALU write-back request.
- alu_reg  in  4  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_rdy  out  1  ALU request accepted this cycle.
- mem_vld  in  1  load write-back request.
- mem_reg  in  4  load destination register.
- mem_data  in  DATA_W  load data.
- mem_rdy  out  1  load request accepted this cycle.
- claim_vld  in  1  decode issues an instruction that will write claim_reg.
- claim_reg  in  4  destination being claimed.
- rs1_en, rs2_en  in  1 each  decode actually uses the corresponding source.
- rs1, rs2  in  4 each  decode source registers.
- stall  out  1  a used source register is busy.
- busy  out  16  scoreboard, bit n = register n has a write in flight.
- claim_err  out  1  one-cycle pulse: the previous cycle claimed a register that was already busy.
- RegWrite  out  1  register file write enable.
- Write_Reg  out  4  register file write address.
- Write_Bus  out  DATA_W  register file write data.

## Operation
- Handshake: a requester holds vld, reg and data stable until its rdy is high in the same cycle (a transfer). rdy is combinational and never high without the matching vld.
- Arbitration (combinational, one grant per cycle):
  - Only one requester valid: it wins.
  - Both valid: MEM wins, unless starve_cnt == STARVE_MAX, in which case ALU wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle alu_vld=1 and alu_rdy=0.
  - Clears when the ALU transfers or when alu_vld=0.
- Write port registers:
  - On a transfer, the winner's reg and data are loaded into Write_Reg/Write_Bus and RegWrite is set for exactly the next cycle.
  - With no transfer, RegWrite=0 and Write_Reg/Write_Bus hold their last values.
- Scoreboard, per register n, evaluated at each posedge:
  - Set when claim_vld=1 and claim_reg==n.
  - Cleared when RegWrite=1 and Write_Reg==n (the commit cycle).
  - Simultaneous set and clear of the same n: set wins, so busy stays 1.
  - A claim while busy[n] is already 1 leaves busy[n]=1 and sets claim_err=1 for the next cycle.
- stall = (rs1_en & busy[rs1]) | (rs2_en & busy[rs2]). It is combinational from the busy register with no bypass: a register whose write commits this cycle still stalls this cycle.
- Registers 14 (data segment) and 15 (stack pointer) have no special treatment in this block.

## Timing
- Reset (asynchronous, immediate): RegWrite=0, Write_Reg=0, Write_Bus=0, busy=0, starve_cnt=0, claim_err=0. alu_rdy and mem_rdy are 0 while rst=1.
- Latency:
  - Transfer at edge N means RegWrite=1 during cycle N+1.
  - The register file captures the data at edge N+1.
  - busy clears at edge N+1, and stall drops in cycle N+2.
- Throughput: one write-back per cycle. Back-to-back transfers produce continuous RegWrite=1.
- Both requesters targeting the same register in one cycle: serialised, winner first; the loser writes in a later cycle.
- Reset asserted mid-operation discards any pending commit: RegWrite is forced to 0 and all busy bits clear. After release, requesters must re-present their requests.

## Test plan
- Reset: assert rst mid-cycle with RegWrite=1 and busy=16'h0014 -> outputs go to 0 immediately, without waiting for clk; first request after release is granted normally.
- Single ALU write: claim r3, then alu_vld with r3 / 16'hBEEF -> alu_rdy=1, next cycle RegWrite=1, Write_Reg=3, Write_Bus=16'hBEEF; busy[3] 1→0; stall with rs1=3, rs1_en=1 is high until the cycle after commit.
- Contention: alu_vld and mem_vld held high continuously with STARVE_MAX=3 -> grant sequence MEM, MEM, MEM, ALU, MEM, MEM, MEM, ALU…
- Same-register collision: ALU r5 = 16'h0001 and MEM r5 = 16'h0002 in the same cycle -> r5 written 16'h0002 then 16'h0001 on consecutive cycles.
- Scoreboard corner cases:
  - Claim r7 while committing r7 -> busy[7] stays 1.
  - Claim r7 again while busy -> claim_err pulses for exactly one cycle.
  - rs2_en=0 with rs2=7 -> no stall.
